timer_bank: RTL and testbench

//  Parametrised multi-channel timer peripheral on the data bus (req/gnt/rvalid). Shared prescaler,
//  NUM_CH independent up-counters with compare, one-shot or periodic (auto-reload) mode,
//  per-channel W1C status and maskable, OR-combined irq. Successor of the single-channel 32-bit timer.

---
 rtl/timer_pkg.sv | 39 +++
 rtl/timer_bank_channel.sv | 71 +++++++
 rtl/timer_bank.sv | 138 +++++++++++++
 tb/tb_timer_bank.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer_bank peripheral: register map offsets,
// channel window geometry, CTRL bit positions, the decoded bus request and
// a byte-enable expander used by every byte-writable register.
package timer_pkg;

  // Global register offsets (data_addr[11:0])
  localparam logic [11:0] REG_GCTRL    = 12'h000;
  localparam logic [11:0] REG_PRESCALE = 12'h004;
  localparam logic [11:0] REG_STATUS   = 12'h008;
  localparam logic [11:0] REG_IRQ_MASK = 12'h00C;

  // Channel window: channel n lives at CH_BASE + CH_STRIDE*n
  localparam logic [11:0] CH_BASE   = 12'h100;
  localparam int          CH_STRIDE = 16;

  // Offsets inside one channel window
  localparam logic [3:0] CH_COUNT   = 4'h0;
  localparam logic [3:0] CH_COMPARE = 4'h4;
  localparam logic [3:0] CH_CTRL    = 4'h8;

  // CTRL bit indices
  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [11:0] off;
    logic [31:0] wdata;
  } bus_req_t;

  // Expand 4 byte enables into a 32-bit write mask.
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

endpackage

// File: rtl/timer_bank_channel.sv
// One timer channel: COUNT, COMPARE and CTRL registers plus match/reload.
// Ports:
//   clk, rst         clock, async active-low reset
//   tick_i           shared prescaler tick (already gated by global run)
//   wr_*_i           bus write strobes for this channel's registers
//   wdata_i/bmask_i  bus write data and expanded byte-enable mask
//   count_o/cmp_o    current COUNT / COMPARE
//   ctrl_o           {periodic, en}
//   set_o            one-cycle pulse: a match happened on this tick
module timer_bank_channel
  import timer_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_i,
  input  logic                 wr_count_i,
  input  logic                 wr_cmp_i,
  input  logic                 wr_ctrl_i,
  input  logic [31:0]          wdata_i,
  input  logic [31:0]          bmask_i,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic [CNT_WIDTH-1:0] cmp_o,
  output logic [1:0]           ctrl_o,
  output logic                 set_o
);

  logic [CNT_WIDTH-1:0] count_q, count_d, cmp_q, cmp_d;
  logic [1:0]           ctrl_q, ctrl_d;
  logic                 hit, match;

  assign hit   = tick_i & ctrl_q[CTRL_EN];
  assign match = (count_q == cmp_q);
  assign set_o = hit & match;

  always_comb begin
    count_d = count_q;
    cmp_d   = cmp_q;
    ctrl_d  = ctrl_q;
    if (hit) begin
      if (match) begin
        if (ctrl_q[CTRL_PERIODIC]) count_d = '0;
        else                       ctrl_d[CTRL_EN] = 1'b0;
      end else begin
        count_d = count_q + 1'b1;   // natural wrap at 2^CNT_WIDTH
      end
    end
    // Bus writes are applied last so they win over a same-cycle tick.
    if (wr_count_i) count_d = CNT_WIDTH'((32'(count_q) & ~bmask_i) | (wdata_i & bmask_i));
    if (wr_cmp_i)   cmp_d   = CNT_WIDTH'((32'(cmp_q) & ~bmask_i) | (wdata_i & bmask_i));
    if (wr_ctrl_i)  ctrl_d  = wdata_i[1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      cmp_q   <= '1;
      ctrl_q  <= '0;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign count_o = count_q;
  assign cmp_o   = cmp_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/timer_bank.sv
// Multi-channel timer peripheral on the req/gnt/rvalid data bus.
// Holds bus decode, shared prescaler, STATUS/IRQ_MASK, the irq register and
// the read mux; NUM_CH timer_bank_channel instances do the counting.
// Ports:
//   clk, rst                      clock, async active-low reset
//   data_req/we/be/addr/wdata     bus request
//   data_gnt/rvalid/rdata         bus response
//   irq                           registered |(status & mask)
module timer_bank
  import timer_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          CNT_WIDTH = 32,
  parameter int          PRE_WIDTH = 16,
  parameter logic [19:0] BASE_ADDR = 20'h00021
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        irq
);

  bus_req_t req;
  logic     accept, wr, rd, busy_q, irq_q, run_q, tick;
  logic     wr_gctrl, wr_pre, wr_stat, wr_mask;
  logic [1:0]  vld_pipe_q;             // [0] gnt, [1] rvalid
  logic [31:0] rdata_q, rd_val, bmask;
  logic [PRE_WIDTH-1:0] prescale_q, pre_q;
  logic [NUM_CH-1:0] status_q, status_d, mask_q, clr, ch_set;
  logic [NUM_CH-1:0] ch_hit, wr_cnt, wr_cmp, wr_ctl;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0] ch_count, ch_cmp;
  logic [NUM_CH-1:0][1:0]           ch_ctrl;

  assign req = '{we: data_we, be: data_be, off: data_addr[11:0], wdata: data_wdata};

  // busy_q keeps a held req from being accepted again: an access ends only
  // when the master drops req.
  assign accept = data_req & (data_addr[31:12] == BASE_ADDR) & ~vld_pipe_q[0] & ~busy_q;
  assign wr     = accept & req.we;
  assign rd     = accept & ~req.we;
  assign bmask  = be_mask(req.be);

  assign wr_gctrl = wr & (req.off == REG_GCTRL) & req.be[0];
  assign wr_pre   = wr & (req.off == REG_PRESCALE);
  assign wr_stat  = wr & (req.off == REG_STATUS) & req.be[0];
  assign wr_mask  = wr & (req.off == REG_IRQ_MASK);

  assign tick = run_q & (pre_q == prescale_q);

  genvar n;
  generate
    for (n = 0; n < NUM_CH; n++) begin : g_ch
      assign ch_hit[n] = ((req.off & 12'hFF0) == CH_BASE + 12'(CH_STRIDE * n));
      assign wr_cnt[n] = wr & ch_hit[n] & (req.off[3:0] == CH_COUNT);
      assign wr_cmp[n] = wr & ch_hit[n] & (req.off[3:0] == CH_COMPARE);
      assign wr_ctl[n] = wr & ch_hit[n] & (req.off[3:0] == CH_CTRL) & req.be[0];

      timer_bank_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
        .clk       (clk),
        .rst       (rst),
        .tick_i    (tick),
        .wr_count_i(wr_cnt[n]),
        .wr_cmp_i  (wr_cmp[n]),
        .wr_ctrl_i (wr_ctl[n]),
        .wdata_i   (req.wdata),
        .bmask_i   (bmask),
        .count_o   (ch_count[n]),
        .cmp_o     (ch_cmp[n]),
        .ctrl_o    (ch_ctrl[n]),
        .set_o     (ch_set[n])
      );
    end
  endgenerate

  // Hardware set is OR-ed after the W1C clear so it wins a collision.
  assign clr      = wr_stat ? req.wdata[NUM_CH-1:0] : '0;
  assign status_d = (status_q & ~clr) | ch_set;

  always_comb begin
    rd_val = '0;
    case (req.off)
      REG_GCTRL:    rd_val = {31'b0, run_q};
      REG_PRESCALE: rd_val = 32'(prescale_q);
      REG_STATUS:   rd_val = 32'(status_q);
      REG_IRQ_MASK: rd_val = 32'(mask_q);
      default:      ;
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_hit[i]) begin
        case (req.off[3:0])
          CH_COUNT:   rd_val = 32'(ch_count[i]);
          CH_COMPARE: rd_val = 32'(ch_cmp[i]);
          CH_CTRL:    rd_val = {30'b0, ch_ctrl[i]};
          default:    ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe_q <= '0;
      busy_q     <= 1'b0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
      run_q      <= 1'b0;
      prescale_q <= '0;
      pre_q      <= '0;
      status_q   <= '0;
      mask_q     <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], accept};
      irq_q      <= |(status_q & mask_q);
      status_q   <= status_d;
      if (accept)         busy_q <= 1'b1;
      else if (!data_req) busy_q <= 1'b0;
      if (rd)       rdata_q <= rd_val;
      if (wr_gctrl) run_q   <= req.wdata[0];
      if (wr_pre)   prescale_q <= PRE_WIDTH'((32'(prescale_q) & ~bmask) | (req.wdata & bmask));
      if (wr_mask)  mask_q     <= NUM_CH'((32'(mask_q) & ~bmask) | (req.wdata & bmask));
      if (wr_pre || tick) pre_q <= '0;
      else if (run_q)     pre_q <= pre_q + 1'b1;
    end
  end

  assign data_gnt    = vld_pipe_q[0];
  assign data_rvalid = vld_pipe_q[1];
  assign data_rdata  = rdata_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_timer_bank.sv
// Bench for timer_bank: directed bus traffic, a register-level model of the
// peripheral checked against gnt/rvalid/rdata/irq every cycle, and literal
// expectations for the timing-critical scenarios.
module tb_timer_bank;
  localparam logic [19:0] BASE = 20'h00021;

  logic        clk = 0, rst = 0, data_req = 0, data_we = 0;
  logic [3:0]  data_be = 0;
  logic [31:0] data_addr = 0, data_wdata = 0;
  logic        data_gnt, data_rvalid, irq;
  logic [31:0] data_rdata;

  int errors = 0, checks = 0, cyc = 0, gnt_cnt = 0, rv_cnt = 0;

  timer_bank #(.NUM_CH(4), .CNT_WIDTH(32), .PRE_WIDTH(16), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .data_req(data_req), .data_we(data_we), .data_be(data_be),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata), .irq(irq));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- model ----------------
  logic [31:0] m_count [4];
  logic [31:0] m_cmp   [4];
  bit          m_en [4], m_per [4];
  logic [3:0]  m_status, m_mask;
  logic [15:0] m_prescale, m_pre;
  logic [31:0] m_rdata;
  bit          m_run, m_gnt, m_rvalid, m_irq, m_busy;

  function automatic logic [31:0] bm(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic mreset();
    for (int c = 0; c < 4; c++) begin
      m_count[c] = 0; m_cmp[c] = 32'hFFFF_FFFF; m_en[c] = 0; m_per[c] = 0;
    end
    m_status = 0; m_mask = 0; m_prescale = 0; m_pre = 0; m_rdata = 0;
    m_run = 0; m_gnt = 0; m_rvalid = 0; m_irq = 0; m_busy = 0;
  endtask

  function automatic logic [31:0] mread(input logic [11:0] off);
    int c;
    c = int'(off[5:4]);
    if (off == 12'h000) return {31'b0, m_run};
    if (off == 12'h004) return {16'b0, m_prescale};
    if (off == 12'h008) return {28'b0, m_status};
    if (off == 12'h00C) return {28'b0, m_mask};
    if (off >= 12'h100 && off < 12'h140) begin
      if (off[3:0] == 4'h0) return m_count[c];
      if (off[3:0] == 4'h4) return m_cmp[c];
      if (off[3:0] == 4'h8) return {30'b0, m_per[c], m_en[c]};
    end
    return 0;
  endfunction

  task automatic mwrite(input logic [11:0] off, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] mk, t;
    int c;
    mk = bm(be);
    c  = int'(off[5:4]);
    if (off == 12'h000 && be[0]) m_run = wd[0];
    if (off == 12'h004) begin t = ({16'b0, m_prescale} & ~mk) | (wd & mk); m_prescale = t[15:0]; m_pre = 0; end
    if (off == 12'h008 && be[0]) m_status = m_status & ~wd[3:0];
    if (off == 12'h00C) begin t = ({28'b0, m_mask} & ~mk) | (wd & mk); m_mask = t[3:0]; end
    if (off >= 12'h100 && off < 12'h140) begin
      if (off[3:0] == 4'h0) m_count[c] = (m_count[c] & ~mk) | (wd & mk);
      if (off[3:0] == 4'h4) m_cmp[c]   = (m_cmp[c] & ~mk) | (wd & mk);
      if (off[3:0] == 4'h8 && be[0]) begin m_en[c] = wd[0]; m_per[c] = wd[1]; end
    end
  endtask

  task automatic mstep();
    bit tick, acc, nirq;
    logic [3:0] set;
    tick = m_run && (m_pre == m_prescale);
    nirq = (m_status & m_mask) != 0;
    acc  = data_req && !m_busy && (data_addr[31:12] == BASE);
    if (acc && !data_we) m_rdata = mread(data_addr[11:0]);
    set = 0;
    for (int c = 0; c < 4; c++) begin
      if (tick && m_en[c]) begin
        if (m_count[c] == m_cmp[c]) begin
          set[c] = 1;
          if (m_per[c]) m_count[c] = 0; else m_en[c] = 0;
        end else m_count[c] = m_count[c] + 1;
      end
    end
    if (m_run) m_pre = tick ? 16'd0 : m_pre + 16'd1;
    if (acc && data_we) mwrite(data_addr[11:0], data_wdata, data_be);
    m_status = m_status | set;
    m_rvalid = m_gnt;
    m_gnt    = acc;
    m_irq    = nirq;
    if (acc) m_busy = 1; else if (!data_req) m_busy = 0;
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) mreset(); else mstep();
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      check("gnt", data_gnt, m_gnt);
      check("rvalid", data_rvalid, m_rvalid);
      check("rdata", data_rdata, m_rdata);
      check("irq", irq, m_irq);
      if (data_gnt) gnt_cnt++;
      if (data_rvalid) rv_cnt++;
    end
  end

  // ---------------- bus helpers ----------------
  task automatic bus(input bit we, input logic [11:0] off, input logic [31:0] wd,
                     input logic [3:0] be, input int hold, output logic [31:0] rdv, output int acc);
    @(negedge clk);
    data_req = 1; data_we = we; data_addr = {BASE, off}; data_wdata = wd; data_be = be;
    @(posedge clk); #1;
    acc = cyc;
    repeat (hold) @(negedge clk);
    data_req = 0; data_we = 0;
    @(negedge clk);
    rdv = data_rdata;
  endtask

  task automatic wr(input logic [11:0] off, input logic [31:0] wd);
    logic [31:0] d; int a;
    bus(1, off, wd, 4'hF, 1, d, a);
  endtask

  task automatic rdc(input string name, input logic [11:0] off, input logic [31:0] exp);
    logic [31:0] d; int a;
    bus(0, off, 0, 4'hF, 1, d, a);
    check(name, d, exp);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Wait so the next bus call accepts on an edge with (edge - r) % 3 == t.
  task automatic align3(input int r, input int t);
    while (((cyc + 2 - r) % 3) != t) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int a, r, g0, v0;

    // 1: reset
    repeat (2) @(negedge clk);
    check("rst_gnt", data_gnt, 0);
    check("rst_rvalid", data_rvalid, 0);
    check("rst_rdata", data_rdata, 0);
    check("rst_irq", irq, 0);
    #2 rst = 1;
    rdc("rst_cmp0", 12'h104, 32'hFFFF_FFFF);
    rdc("rst_status", 12'h008, 0);

    // 2: one-shot with prescaler
    wr(12'h004, 3);
    wr(12'h104, 5);
    wr(12'h108, 1);
    wr(12'h00C, 1);
    bus(1, 12'h000, 1, 4'hF, 1, d, r);
    while (irq !== 1'b1 && cyc < r + 60) @(negedge clk);
    check("oneshot_irq_delay", cyc - r, 25);
    rdc("oneshot_status", 12'h008, 1);
    rdc("oneshot_ctrl", 12'h108, 0);
    rdc("oneshot_count", 12'h100, 5);

    // 3: periodic ch1, prescale 0
    wr(12'h000, 0);
    wr(12'h004, 0);
    wr(12'h008, 1);
    wr(12'h00C, 2);
    wr(12'h114, 2);
    wr(12'h118, 3);
    rdc("per_status_clr", 12'h008, 0);
    bus(1, 12'h000, 1, 4'hF, 1, d, r);
    wait_cyc(r + 3); check("per_irq_low", irq, 0);
    wait_cyc(r + 4); check("per_irq_rise", irq, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus(0, 12'h110, 0, 4'hF, 1, d, a);
      check("per_count", d, (a - 1 - r) % 3);
    end
    align3(r, 0);
    bus(1, 12'h008, 2, 4'hF, 1, d, a);
    for (int k = 1; k <= 4; k++) begin wait_cyc(a + k); check("w1c_vs_set", irq, 1); end
    align3(r, 1);
    bus(1, 12'h008, 2, 4'hF, 1, d, a);
    wait_cyc(a + 1); check("w1c_irq0", irq, 0);
    wait_cyc(a + 2); check("w1c_irq1", irq, 0);
    wait_cyc(a + 3); check("w1c_reassert", irq, 1);

    // 4: held request -> single access
    wr(12'h128, 1);
    g0 = gnt_cnt; v0 = rv_cnt;
    bus(1, 12'h120, 32'h1234, 4'hF, 5, d, a);
    repeat (2) @(negedge clk);
    check("held_gnt_pulses", gnt_cnt - g0, 1);
    check("held_rvalid_pulses", rv_cnt - v0, 1);
    bus(0, 12'h120, 0, 4'hF, 1, d, r);
    check("held_single_write", d, 32'h1234 + (r - 1 - a));
    wr(12'h128, 0);

    // 5: byte enables, unmapped, out-of-range channel
    wr(12'h134, 0);
    bus(1, 12'h134, 32'hAABBCCDD, 4'b0101, 1, d, a);
    rdc("be_compare", 12'h134, 32'h00BB00DD);
    wr(12'h140, 32'h55);
    rdc("ch4_read", 12'h140, 0);
    rdc("unmapped_10c", 12'h10C, 0);

    // 6: reset mid-access with irq high
    check("pre_rst_irq", irq, 1);
    @(negedge clk);
    data_req = 1; data_we = 0; data_addr = {BASE, 12'h114}; data_be = 4'hF;
    @(posedge clk); #1;
    check("pre_rst_gnt", data_gnt, 1);
    rst = 0;
    #1;
    check("async_irq", irq, 0);
    check("async_gnt", data_gnt, 0);
    check("async_rvalid", data_rvalid, 0);
    check("async_rdata", data_rdata, 0);
    data_req = 0;
    repeat (2) @(negedge clk);
    #2 rst = 1;
    rdc("post_rst_cmp0", 12'h104, 32'hFFFF_FFFF);
    rdc("unmapped_0f0", 12'h0F0, 0);
    rdc("post_rst_status", 12'h008, 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
